// File: rtl/serial_tx_pkg.sv
// Shared types and line-level constants for the serial transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width for a 0..n-1 range; a single-value range still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Parallel-in handshake plus the true/complement serial line of serial_tx.
interface serial_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx;
    logic              tx_n;
    logic              busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx,
        input  tx_n,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx,
        output tx_n,
        output busy
    );
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: tick marks the last cycle of each CLKS_PER_BIT period.
module bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int unsigned      CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // With one clock per bit LAST is zero, so tick stays high and cnt_q stays at 0.
    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/serial_tx.sv
// LSB-first serial transmitter: start, DATA_W data bits, optional even parity, stop.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic           clk,
    input  logic           rst,
    serial_tx_if.slave     bus
);
    localparam int unsigned      IDX_W    = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              tx_n_q;
    logic              timer_clr;
    logic              tick;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        par_d     = par_q;
        timer_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    shreg_d   = bus.tx_data;
                    par_d     = ^bus.tx_data;
                    timer_clr = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx flips on the same edge as the state.
    always_comb begin
        tx_d = LINE_IDLE;
        unique case (state_d)
            IDLE:    tx_d = LINE_IDLE;
            START:   tx_d = START_BIT;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= LINE_IDLE;
            tx_n_q  <= ~LINE_IDLE;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            tx_n_q  <= ~tx_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_n     = tx_n_q;
    assign bus.tx_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
endmodule
